// File: rtl/fir_mac_seq.sv
// Time-multiplexed FIR multiply-accumulate: snapshots the tap vector on start, does one
// signed tap*coef per cycle, then rounds/saturates the sum into a single output sample.
module fir_mac_seq #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_REGS   = 8,
   parameter int COEF_WIDTH = 16,
   parameter int COEF_FRAC  = 15,
   parameter int ACC_WIDTH  = DATA_WIDTH + COEF_WIDTH + $clog2(NUM_REGS)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [DATA_WIDTH*NUM_REGS-1:0] pDataIn,
   input  logic                           coefWe,
   input  logic [$clog2(NUM_REGS)-1:0]    coefAddr,
   input  logic [COEF_WIDTH-1:0]          coefData,
   output logic [DATA_WIDTH-1:0]          yOut,
   output logic                           yValid,
   output logic                           busy,
   output logic                           overrun,
   output logic                           coefErr
);

   localparam int AW = $clog2(NUM_REGS);
   localparam int PW = DATA_WIDTH + COEF_WIDTH;
   localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);
   localparam logic signed [ACC_WIDTH-1:0] RND  = ACC_WIDTH'(1) << (COEF_FRAC - 1);
   localparam logic signed [ACC_WIDTH-1:0] YMAX =
      {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] YMIN =
      {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

   state_t                        r_state;
   state_t                        w_state_next;
   logic signed [DATA_WIDTH-1:0]  r_snap [NUM_REGS];
   logic signed [COEF_WIDTH-1:0]  r_coef [NUM_REGS];
   logic signed [ACC_WIDTH-1:0]   r_acc;
   logic [AW-1:0]                 r_idx;
   logic [DATA_WIDTH-1:0]         r_yout;
   logic                          r_coef_err;
   logic                          r_overrun;
   logic signed [PW-1:0]          w_prod;
   logic signed [ACC_WIDTH-1:0]   w_acc_next;
   logic                          w_in_mac;
   logic                          w_accept;
   logic                          w_addr_ok;
   logic                          w_coef_wr;
   logic                          w_coef_err;

   function automatic logic [DATA_WIDTH-1:0] sat_round(input logic signed [ACC_WIDTH-1:0] a);
      logic signed [ACC_WIDTH-1:0] r;
      r = (a + RND) >>> COEF_FRAC;
      if (r > YMAX)      return YMAX[DATA_WIDTH-1:0];
      else if (r < YMIN) return YMIN[DATA_WIDTH-1:0];
      else               return r[DATA_WIDTH-1:0];
   endfunction

   assign w_in_mac   = (r_state == S_MAC);
   // DONE behaves like IDLE for new starts, enabling back-to-back samples
   assign w_accept   = start && !w_in_mac;
   assign w_addr_ok  = (int'(coefAddr) < NUM_REGS);
   assign w_coef_wr  = coefWe && !w_in_mac && w_addr_ok;
   assign w_coef_err = coefWe && !w_coef_wr;
   assign w_prod     = PW'(r_snap[r_idx]) * PW'(r_coef[r_idx]);
   assign w_acc_next = r_acc + ACC_WIDTH'(w_prod);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_next = S_MAC;
         S_MAC:   if (r_idx == LAST_IDX) w_state_next = S_DONE;
         S_DONE:  w_state_next = start ? S_MAC : S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_snap[i] <= '0;
            r_coef[i] <= '0;
         end
         r_acc      <= '0;
         r_idx      <= '0;
         r_yout     <= '0;
         r_coef_err <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         if (w_accept) begin
            for (int i = 0; i < NUM_REGS; i++)
               r_snap[i] <= $signed(pDataIn[i*DATA_WIDTH +: DATA_WIDTH]);
            r_acc <= '0;
            r_idx <= '0;
         end else if (w_in_mac) begin
            r_acc <= w_acc_next;
            // idx parks on the last tap so the product mux never sees an out-of-range index
            if (r_idx == LAST_IDX) r_yout <= sat_round(w_acc_next);
            else                   r_idx  <= r_idx + AW'(1);
         end
         if (w_coef_wr) r_coef[coefAddr] <= $signed(coefData);
         r_coef_err <= w_coef_err;
         if (start && w_in_mac) r_overrun <= 1'b1;
      end
   end

   assign yOut    = r_yout;
   assign yValid  = (r_state == S_DONE);
   assign busy    = w_in_mac;
   assign overrun = r_overrun;
   assign coefErr = r_coef_err;

endmodule

// File: tb/tb_fir_mac_seq.sv
// Directed bench for fir_mac_seq: a cycle-indexed reference model checked every cycle,
// plus hand-computed sample values and latencies for each scenario.
module tb_fir_mac_seq;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [127:0] pDataIn;
   logic         coefWe;
   logic [2:0]   coefAddr;
   logic [15:0]  coefData;
   logic [15:0]  yOut;
   logic         yValid;
   logic         busy;
   logic         overrun;
   logic         coefErr;

   int total = 0;
   int bad   = 0;

   fir_mac_seq dut (
      .clk(clk), .rst(rst), .start(start), .pDataIn(pDataIn),
      .coefWe(coefWe), .coefAddr(coefAddr), .coefData(coefData),
      .yOut(yOut), .yValid(yValid), .busy(busy), .overrun(overrun), .coefErr(coefErr)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a result is the rounded, clamped dot product of the taps and the
   // coefficients present when the start is accepted; it appears 9 cycles later.
   logic signed [15:0] m_coef [8];
   longint m_cyc = 0;
   longint m_t0  = 0;
   bit     m_active = 0;
   bit     m_ready  = 0;
   logic [15:0] m_res;
   logic        e_valid, e_busy, e_overrun, e_coeferr;
   logic [15:0] e_yout;

   function automatic logic [15:0] model_y();
      longint s = 0;
      longint r;
      for (int i = 0; i < 8; i++)
         s += longint'($signed(pDataIn[i*16 +: 16])) * longint'(m_coef[i]);
      r = (s + 64'sd16384) >>> 15;
      if (r > 32767)  r = 32767;
      if (r < -32768) r = -32768;
      return r[15:0];
   endfunction

   initial begin
      longint t, c;
      bit in_mac;
      forever begin
         @(posedge clk);
         t = m_cyc;
         m_cyc++;
         if (!rst) begin
            for (int i = 0; i < 8; i++) m_coef[i] = '0;
            m_active = 0; e_valid = 0; e_busy = 0; e_overrun = 0; e_coeferr = 0; e_yout = '0;
         end else begin
            in_mac    = m_active && t >= m_t0 + 1 && t <= m_t0 + 8;
            e_coeferr = coefWe && in_mac;
            if (coefWe && !in_mac) m_coef[coefAddr] = $signed(coefData);
            if (start && in_mac) e_overrun = 1'b1;
            if (start && !in_mac) begin
               m_res = model_y();
               m_t0 = t;
               m_active = 1;
            end
            c = t + 1;
            e_valid = m_active && c == m_t0 + 9;
            if (e_valid) e_yout = m_res;
            e_busy = m_active && c >= m_t0 + 1 && c <= m_t0 + 8;
         end
         m_ready = 1;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (m_ready) begin
            check("cmp_yValid",  yValid,  e_valid);
            check("cmp_busy",    busy,    e_busy);
            check("cmp_overrun", overrun, e_overrun);
            check("cmp_coefErr", coefErr, e_coeferr);
            check("cmp_yOut",    yOut,    e_yout);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic set_all(input logic [15:0] v);
      for (int i = 0; i < 8; i++) pDataIn[i*16 +: 16] = v;
   endtask

   task automatic write_coef(input logic [2:0] a, input logic [15:0] d);
      coefWe = 1'b1; coefAddr = a; coefData = d;
      tick();
      coefWe = 1'b0;
   endtask

   // k0 is the number of cycles already elapsed since the start cycle
   task automatic wait_valid(input string nm, input int k0, input logic [15:0] exp_y);
      int k = k0;
      while (yValid !== 1'b1 && k < 30) begin
         tick();
         k++;
      end
      check({nm, "_latency"}, k, 9);
      check({nm, "_yOut"}, yOut, exp_y);
   endtask

   task automatic run_start(input string nm, input logic [15:0] exp_y);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_valid(nm, 1, exp_y);
   endtask

   initial begin
      int seen;
      rst = 1'b0; start = 1'b0; coefWe = 1'b0; coefAddr = '0; coefData = '0; pDataIn = '0;
      repeat (3) tick();
      rst = 1'b1;
      tick();

      // reset state, then a run with all-zero coefficients
      check("rst_yOut", yOut, 0);
      check("rst_yValid", yValid, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun, 0);
      check("rst_coefErr", coefErr, 0);
      for (int i = 0; i < 8; i++) pDataIn[i*16 +: 16] = 16'(100 * (i + 1));
      run_start("zero_coef", 16'h0000);
      tick();

      // 0.5*0x1000 + 0.25*0x1000 = 0x0C00
      write_coef(3'd0, 16'h4000);
      write_coef(3'd1, 16'h2000);
      set_all(16'h1000);
      run_start("impulse", 16'h0C00);
      tick();

      // second start at T+3 ignored (taps changed meanwhile), then a start in the DONE cycle
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      start = 1'b1;
      set_all(16'h2000);
      tick();
      start = 1'b0;
      wait_valid("overrun_first", 4, 16'h0C00);
      check("overrun_set", overrun, 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_valid("done_restart", 1, 16'h1800);
      check("overrun_sticky", overrun, 1);
      tick();

      // coefficient write during MAC is rejected; in IDLE with start it is used
      set_all(16'h1000);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      coefWe = 1'b1; coefAddr = 3'd2; coefData = 16'h4000;
      tick();
      coefWe = 1'b0;
      check("coefErr_pulse", coefErr, 1);
      tick();
      check("coefErr_clear", coefErr, 0);
      wait_valid("coef_in_mac", 6, 16'h0C00);
      tick();
      coefWe = 1'b1; coefAddr = 3'd2; coefData = 16'h4000;
      start = 1'b1;
      tick();
      coefWe = 1'b0;
      start = 1'b0;
      check("coefErr_idle", coefErr, 0);
      wait_valid("coef_with_start", 1, 16'h1400);
      tick();

      // saturation both ways
      for (int i = 0; i < 8; i++) write_coef(3'(i), 16'h7FFF);
      set_all(16'h7FFF);
      run_start("sat_pos", 16'h7FFF);
      tick();
      set_all(16'h8000);
      run_start("sat_neg", 16'h8000);
      tick();

      // reset in the middle of a computation
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      rst = 1'b0;
      tick();
      check("midrst_yOut", yOut, 0);
      check("midrst_busy", busy, 0);
      check("midrst_overrun", overrun, 0);
      check("midrst_yValid", yValid, 0);
      tick();
      rst = 1'b1;
      seen = 0;
      repeat (12) begin
         tick();
         if (yValid === 1'b1) seen++;
      end
      check("midrst_no_valid", seen, 0);
      for (int i = 0; i < 8; i++) pDataIn[i*16 +: 16] = 16'(100 * (i + 1));
      run_start("after_rst", 16'h0000);
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
